// File: rtl/seg7_pair_decoder_if.sv
// seg7_pair_decoder_if: segment sample bus in, decoded value handshake and error pulses out
//  seg_in/seg_dig/seg_stb : strobed segment pattern and digit select (master -> slave)
//  out_ready              : consumer accept (master -> slave)
//  out_valid/out_value/out_tens/out_ones : decoded frame (slave -> master)
//  err_pattern/err_timeout : one-cycle error pulses (slave -> master)
interface seg7_pair_decoder_if;
  logic [6:0] seg_in;
  logic seg_dig;
  logic seg_stb;
  logic out_ready;
  logic out_valid;
  logic [6:0] out_value;
  logic [3:0] out_tens;
  logic [3:0] out_ones;
  logic err_pattern;
  logic err_timeout;
  modport master (
    output seg_in, seg_dig, seg_stb, out_ready,
    input out_valid, out_value, out_tens, out_ones, err_pattern, err_timeout
  );
  modport slave (
    input seg_in, seg_dig, seg_stb, out_ready,
    output out_valid, out_value, out_tens, out_ones, err_pattern, err_timeout
  );
endinterface

// File: rtl/seg7_pair_decoder.sv
// seg7_pair_decoder: decodes time-multiplexed two-digit 7-segment frames to a 0..99 value
//  clk, rst : clock and synchronous active-high reset
//  bus      : seg7_pair_decoder_if.slave (segment samples in, value/handshake/errors out)
module seg7_pair_decoder #(
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  seg7_pair_decoder_if.slave bus
);
  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, GOT_TENS, COMPARE, HOLD} state_t;
  state_t state;
  logic [3:0] tens_r, ones_r;
  logic [7:0] last_frame, emit_frame;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [TW-1:0] tmo;
  logic emitted;
  logic [4:0] dec;
  logic legal, fire;
  logic [3:0] digit;
  logic [7:0] frame;
  always_comb begin
    dec = 5'h00;
    case (bus.seg_in)
      7'b1111110: dec = 5'h10;
      7'b0110000: dec = 5'h11;
      7'b1101101: dec = 5'h12;
      7'b1111001: dec = 5'h13;
      7'b0110011: dec = 5'h14;
      7'b1011011: dec = 5'h15;
      7'b1011111: dec = 5'h16;
      7'b1110000: dec = 5'h17;
      7'b1111111: dec = 5'h18;
      7'b1111011: dec = 5'h19;
      default: dec = 5'h00;
    endcase
  end
  assign legal = dec[4];
  assign digit = dec[3:0];
  assign frame = {tens_r, ones_r};
  assign nxt_cnt = (frame == last_frame) ? ((cnt == CNT_MAX) ? cnt : cnt + 1'b1) : CW'(1);
  // a frame already emitted is not re-emitted while it keeps repeating
  assign fire = (nxt_cnt == CNT_MAX) && (!emitted || frame != emit_frame);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tens_r <= '0;
      ones_r <= '0;
      last_frame <= '0;
      emit_frame <= '0;
      cnt <= '0;
      tmo <= '0;
      emitted <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_value <= '0;
      bus.out_tens <= '0;
      bus.out_ones <= '0;
      bus.err_pattern <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.err_pattern <= 1'b0;
      bus.err_timeout <= 1'b0;
      case (state)
        IDLE: if (bus.seg_stb && !bus.seg_dig) begin
          if (legal) begin
            tens_r <= digit;
            tmo <= '0;
            state <= GOT_TENS;
          end else begin
            bus.err_pattern <= 1'b1;
            cnt <= '0;
          end
        end
        GOT_TENS: if (bus.seg_stb) begin
          if (!legal) begin
            bus.err_pattern <= 1'b1;
            cnt <= '0;
            state <= IDLE;
          end else if (bus.seg_dig) begin
            ones_r <= digit;
            state <= COMPARE;
          end else begin
            tens_r <= digit;
            tmo <= '0;
          end
        end else if (tmo == TMO_LAST) begin
          bus.err_timeout <= 1'b1;
          cnt <= '0;
          state <= IDLE;
        end else tmo <= tmo + 1'b1;
        COMPARE: begin
          cnt <= nxt_cnt;
          last_frame <= frame;
          if (fire) begin
            bus.out_tens <= tens_r;
            bus.out_ones <= ones_r;
            bus.out_value <= {3'b000, tens_r} * 7'd10 + {3'b000, ones_r};
            emitted <= 1'b1;
            emit_frame <= frame;
            state <= HOLD;
          end else state <= IDLE;
        end
        // valid rises one cycle after entering HOLD, giving the two-edge output latency
        HOLD: if (!bus.out_valid) bus.out_valid <= 1'b1;
        else if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg7_pair_decoder.sv
// tb_seg7_pair_decoder: directed-vector self-checking bench for seg7_pair_decoder
module tb_seg7_pair_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int tmo_k;
  localparam logic [6:0] SEG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  seg7_pair_decoder_if bus();
  seg7_pair_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic [6:0] s, input logic d);
    @(negedge clk);
    bus.seg_in = s;
    bus.seg_dig = d;
    bus.seg_stb = 1'b1;
    @(negedge clk);
    bus.seg_stb = 1'b0;
  endtask
  task automatic frame(input int t, input int o);
    strobe(SEG[t], 1'b0);
    strobe(SEG[o], 1'b1);
  endtask
  task automatic expect_out(input string tag, input logic emit, input int v);
    @(negedge clk);
    chk({tag, "_lat"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, bus.out_valid, emit);
    if (emit) begin
      chk({tag, "_value"}, bus.out_value, v);
      chk({tag, "_tens"}, bus.out_tens, v / 10);
      chk({tag, "_ones"}, bus.out_ones, v % 10);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_value"}, bus.out_value, 0);
    chk({tag, "_tens"}, bus.out_tens, 0);
    chk({tag, "_ones"}, bus.out_ones, 0);
    chk({tag, "_errp"}, bus.err_pattern, 0);
    chk({tag, "_errt"}, bus.err_timeout, 0);
  endtask
  initial begin
    bus.seg_in = '0;
    bus.seg_dig = 1'b0;
    bus.seg_stb = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("rst");
    frame(3, 5);
    expect_out("t1a", 1'b0, 0);
    frame(3, 5);
    expect_out("t1b", 1'b1, 35);
    @(negedge clk);
    chk("t1_drop", bus.out_valid, 0);
    frame(3, 5);
    expect_out("t2_rep", 1'b0, 0);
    frame(9, 9);
    expect_out("t2a", 1'b0, 0);
    frame(9, 9);
    expect_out("t2b", 1'b1, 99);
    strobe(7'b0000001, 1'b0);
    chk("t3_errp", bus.err_pattern, 1);
    @(negedge clk);
    chk("t3_errp_pulse", bus.err_pattern, 0);
    chk("t3_noval", bus.out_valid, 0);
    strobe(SEG[5], 1'b0);
    strobe(7'b0000000, 1'b1);
    chk("t3_errp_ones", bus.err_pattern, 1);
    frame(1, 2);
    expect_out("t3a", 1'b0, 0);
    frame(1, 2);
    expect_out("t3b", 1'b1, 12);
    strobe(SEG[3], 1'b0);
    tmo_k = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.err_timeout) begin
        tmo_k = k;
        break;
      end
    end
    chk("t4_tmo_cycles", tmo_k, 255);
    @(negedge clk);
    chk("t4_tmo_pulse", bus.err_timeout, 0);
    chk("t4_noval", bus.out_valid, 0);
    frame(4, 0);
    expect_out("t4a", 1'b0, 0);
    frame(4, 0);
    expect_out("t4b", 1'b1, 40);
    @(negedge clk);
    bus.out_ready = 1'b0;
    frame(4, 2);
    expect_out("t5a", 1'b0, 0);
    frame(4, 2);
    expect_out("t5b", 1'b1, 42);
    for (int i = 0; i < 5; i++) begin
      frame(7, 7);
      chk("t5_hold_valid", bus.out_valid, 1);
      chk("t5_hold_value", bus.out_value, 42);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_release", bus.out_valid, 0);
    chk("t5_keep", bus.out_value, 42);
    frame(1, 1);
    expect_out("t6_11a", 1'b0, 0);
    frame(1, 1);
    expect_out("t6_11b", 1'b1, 11);
    frame(4, 2);
    expect_out("t6a", 1'b0, 0);
    bus.out_ready = 1'b0;
    frame(4, 2);
    expect_out("t6b", 1'b1, 42);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("t6_rst");
    bus.out_ready = 1'b1;
    frame(4, 2);
    expect_out("t6c", 1'b0, 0);
    frame(4, 2);
    expect_out("t6d", 1'b1, 42);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
